// File: rtl/pfd_sync_cnt.sv
// Synchronous tri-state PFD with signed phase-error counter and optional lock detect.
// Define PFD_LOCK_DET_EN to build the lock detector; otherwise locked is tied low.
module pfd_sync_cnt #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 0,
    parameter int LOCK_TOL    = 4,
    parameter int LOCK_CNT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ref_in,
    input  logic                    vco_in,
    output logic                    up,
    output logic                    dn,
    output logic signed [CNT_W-1:0] err,
    output logic                    err_valid,
    output logic                    locked
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam int               PW       = $clog2(MIN_PULSE + 2);
    localparam logic [PW-1:0]    PULSE_LD = PW'((MIN_PULSE > 0) ? MIN_PULSE - 1 : 0);
    localparam logic             USE_BOTH = (MIN_PULSE > 0);

    typedef enum logic [1:0] {
        IDLE,
        LEAD_R,
        LEAD_V,
        BOTH
    } state_t;

    logic [SYNC_STAGES-1:0]  ref_sync_q, ref_sync_d;
    logic [SYNC_STAGES-1:0]  vco_sync_q, vco_sync_d;
    logic                    ref_prev_q, ref_prev_d;
    logic                    vco_prev_q, vco_prev_d;
    logic                    r_rise, v_rise;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]           pulse_q, pulse_d;
    logic                    up_q, up_d;
    logic                    dn_q, dn_d;
    logic signed [CNT_W-1:0] err_q, err_d;
    logic                    err_valid_q, err_valid_d;

    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], ref_in};
        vco_sync_d = {vco_sync_q[SYNC_STAGES-2:0], vco_in};
        ref_prev_d = ref_sync_q[SYNC_STAGES-1];
        vco_prev_d = vco_sync_q[SYNC_STAGES-1];
        r_rise     = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
        v_rise     = vco_sync_q[SYNC_STAGES-1] & ~vco_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        err_d       = err_q;
        err_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (r_rise && v_rise) begin
                    err_d       = '0;
                    err_valid_d = 1'b1;
                    if (USE_BOTH) begin
                        state_d = BOTH;
                        pulse_d = PULSE_LD;
                    end
                end else if (r_rise) begin
                    state_d = LEAD_R;
                    cnt_d   = CNT_W'(1);
                end else if (v_rise) begin
                    state_d = LEAD_V;
                    cnt_d   = CNT_W'(1);
                end
            end
            // Repeat edges of the leading input are ignored until the other closes.
            LEAD_R: begin
                if (v_rise) begin
                    err_d       = cnt_q;
                    err_valid_d = 1'b1;
                    state_d     = USE_BOTH ? BOTH : IDLE;
                    pulse_d     = PULSE_LD;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LEAD_V: begin
                if (r_rise) begin
                    err_d       = -cnt_q;
                    err_valid_d = 1'b1;
                    state_d     = USE_BOTH ? BOTH : IDLE;
                    pulse_d     = PULSE_LD;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BOTH: begin
                if (pulse_q == '0) begin
                    state_d = IDLE;
                end else begin
                    pulse_d = pulse_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        up_d = (state_d == LEAD_R) || (state_d == BOTH);
        dn_d = (state_d == LEAD_V) || (state_d == BOTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_sync_q  <= '0;
            vco_sync_q  <= '0;
            ref_prev_q  <= 1'b0;
            vco_prev_q  <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
        end else begin
            ref_sync_q  <= ref_sync_d;
            vco_sync_q  <= vco_sync_d;
            ref_prev_q  <= ref_prev_d;
            vco_prev_q  <= vco_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign up        = up_q;
    assign dn        = dn_q;
    assign err       = err_q;
    assign err_valid = err_valid_q;

`ifdef PFD_LOCK_DET_EN
    localparam int                      GW       = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]           GOOD_MAX = GW'(LOCK_CNT);
    localparam logic signed [CNT_W-1:0] TOL_P    = CNT_W'(LOCK_TOL);
    localparam logic signed [CNT_W-1:0] TOL_N    = -TOL_P;

    logic [GW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic          in_tol;

    // Judged on the registered strobe so locked lags it by exactly one cycle.
    always_comb begin
        in_tol = (err_q <= TOL_P) && (err_q >= TOL_N);
        good_d = good_q;
        if (err_valid_q) begin
            if (!in_tol) begin
                good_d = '0;
            end else if (good_q != GOOD_MAX) begin
                good_d = good_q + 1'b1;
            end
        end
        locked_d = (good_d == GOOD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            good_q   <= good_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

endmodule

// File: doc/pfd_sync_cnt.md
# pfd_sync_cnt

Clocked, parametrised phase-frequency detector for the DualFFPfdPLL family. It replaces the asynchronous dual-flip-flop PFD with a fully synchronous tri-state PFD. The block samples `ref_in` and `vco_in` through synchronisers and drives UP/DN pulses. It also measures each phase error as a signed cycle count for a digital loop filter and, optionally, reports lock.

## Interface
- `CNT_W`, 16: width of signed error output; counts saturate at ±(2^(CNT_W-1)-1).
- `SYNC_STAGES`, 2: synchroniser depth per input, ≥2.
- `MIN_PULSE`, 0: anti-dead-zone; cycles both `up` and `dn` stay high after a measurement closes (0 = none).
- `LOCK_TOL`, 4: max |err| counted as in-lock.
- `LOCK_CNT`, 16: consecutive in-lock measurements required to assert `locked`.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ref_in` in 1: reference clock, asynchronous to `clk`.
- `vco_in` in 1: feedback/VCO clock, asynchronous to `clk`.
- `up` out 1: registered; high while ref leads.
- `dn` out 1: registered; high while vco leads.
- `err` out CNT_W signed: last measured phase error in `clk` cycles; + = ref leads.
- `err_valid` out 1: one-cycle strobe qualifying `err`.
- `locked` out 1: lock indicator.

## Operation
- Each input passes through a SYNC_STAGES flop chain, then a rising-edge detector: `r_rise`/`v_rise` = last stage high and previous-cycle value low.
- FSM states:
  - IDLE: up=0, dn=0.
    - `r_rise` & `v_rise` together → `err`=0, strobe `err_valid`; go to BOTH if MIN_PULSE>0, else stay in IDLE.
    - `r_rise` only → LEAD_R, cnt=1.
    - `v_rise` only → LEAD_V, cnt=1.
  - LEAD_R: up=1.
    - cnt increments each cycle, saturating at 2^(CNT_W-1)-1.
    - `v_rise` → `err`=+cnt, strobe; go to BOTH, or IDLE if MIN_PULSE=0.
    - Further `r_rise` edges are ignored (frequency-error behaviour; up stays high).
  - LEAD_V: mirror of LEAD_R with dn=1; `err`=−cnt on `r_rise`.
  - BOTH: up=1, dn=1 for exactly MIN_PULSE cycles, then IDLE. All edges arriving in BOTH are dropped.
- Simultaneous `r_rise` & `v_rise` in LEAD_R or LEAD_V: the closing edge ends the measurement; the opposite edge is dropped, and no new measurement starts.
- `err` holds its value between strobes.
- Lock detector (see Configuration):
  - On each strobe with |err|≤LOCK_TOL, good count increments, saturating at LOCK_CNT.
  - On a strobe with |err|>LOCK_TOL, good count clears to 0.
  - `locked` = (good count == LOCK_CNT), registered.
- Reset clears the synchronisers and edge-history flops to 0; state goes to IDLE.
- Reset values: up=0, dn=0, err=0, err_valid=0, locked=0, cnt=0, good count=0.
- An input already high at reset release produces one rising edge.
- Reset asserted mid-measurement aborts it with no strobe.

## Timing
- Input rising edge first sampled high at `clk` edge k → `r_rise`/`v_rise` at edge k+SYNC_STAGES−1 → `up`/`dn` high after edge k+SYNC_STAGES.
- Closing edge detected at cycle c after opening edge at cycle o gives err = c−o.
- `err`/`err_valid` update after the closing edge's detection cycle, the same edge on which `up`/`dn` change.
- `locked` updates one cycle after the qualifying strobe.
- Throughput: one measurement per ref/vco edge pair, plus MIN_PULSE dead cycles.

## Configuration
- Macro `PFD_LOCK_DET_EN`.
- Defined: lock detector built as specified.
- Undefined: no good counter or comparator is built; `locked` is tied to 0. The port remains.

## Test plan
- Reset, then ref leads vco by 5 cycles (SYNC_STAGES=2, MIN_PULSE=0) → up high for 5 cycles, err=+5 with a single err_valid; dn never high.
- Vco leads ref by 7 cycles → dn high for 7 cycles, err=−7 (0x…F9); up never high.
- Coincident edges with MIN_PULSE=3 → err=0 strobe; up=dn=1 for exactly 3 cycles. Edges injected during BOTH produce no new strobe.
- CNT_W=4, ref leads by 20 cycles → err saturates at +7; two extra ref edges before the vco edge do not restart the count.
- `PFD_LOCK_DET_EN` defined, LOCK_TOL=1, LOCK_CNT=4: errors 0,1,−1,0 → locked=1 one cycle after the 4th strobe; next err=+3 → locked=0. Macro undefined → locked stays 0.
- Assert rst during LEAD_R → up=0 next cycle; no err_valid; a clean measurement follows after reset release.
